// File: rtl/fifo_pkg.sv
// Shared sizing helpers and constants for the memory-backed FIFO controller.
// Pointer and counter widths are derived here so every file agrees on them.
package fifo_pkg;

    localparam int OB_DEPTH = 2;

    typedef logic [1:0] ob_cnt_t;

    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int mem_cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Total occupancy covers the memory, one in-flight read and the out buffer.
    function automatic int cnt_bits(input int depth);
        return $clog2(depth + OB_DEPTH + 1);
    endfunction

endpackage

// File: rtl/mem_fifo_outbuf.sv
// Two-entry FIFO that captures read data returning from the memory and
// presents the oldest captured word as the pop-side head.
module mem_fifo_outbuf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_valid_in,
    input  logic [WIDTH-1:0] cap_data_in,
    input  logic             pop_ready_in,
    output logic             pop_valid_out,
    output logic [WIDTH-1:0] pop_data_out,
    output logic             pop_fire_out,
    output ob_cnt_t          cnt_out
);

    localparam ob_cnt_t OB_FULL = ob_cnt_t'(OB_DEPTH);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    ob_cnt_t          cnt_q;

    assign pop_valid_out = (cnt_q != 2'd0);
    assign pop_fire_out  = pop_valid_out && pop_ready_in;
    assign pop_data_out  = head_q;
    assign cnt_out       = cnt_q;

    // A capture always lands behind whatever is still waiting, so a
    // simultaneous pop shifts the tail forward before the new word enters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({cap_valid_in, pop_fire_out})
                2'b10: begin
                    if (cnt_q != OB_FULL) begin
                        if (cnt_q == 2'd0) begin
                            head_q <= cap_data_in;
                        end else begin
                            tail_q <= cap_data_in;
                        end
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= cap_data_in;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= cap_data_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Pointer and flow-control stage in front of a 1-cycle-latency memory,
// presenting the memory plus a 2-word out buffer as a valid/ready FIFO.
module mem_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH_BYTES = 4,
    parameter int DEPTH       = 16,
    parameter int AFULL_LVL   = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_valid_in,
    input  logic [WIDTH_BYTES*8-1:0]      push_data_in,
    output logic                          push_ready_out,
    output logic                          pop_valid_out,
    output logic [WIDTH_BYTES*8-1:0]      pop_data_out,
    input  logic                          pop_ready_in,
    output logic [$clog2(DEPTH+3)-1:0]    count_out,
    output logic                          almost_full_out,
    output logic [$clog2(DEPTH)-1:0]      mem_write_addr_out,
    output logic                          mem_write_out,
    output logic [WIDTH_BYTES*8-1:0]      mem_write_data_out,
    output logic [WIDTH_BYTES-1:0]        mem_write_mask_out,
    output logic [$clog2(DEPTH)-1:0]      mem_read_addr_out,
    output logic                          mem_read_out,
    input  logic [WIDTH_BYTES*8-1:0]      mem_read_data_in,
    input  logic                          debugen_in
);

    localparam int W     = WIDTH_BYTES * 8;
    localparam int PTR_W = ptr_bits(DEPTH);
    localparam int MC_W  = mem_cnt_bits(DEPTH);
    localparam int CNT_W = cnt_bits(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [MC_W-1:0]  mcnt_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam mcnt_t MEM_FULL = mcnt_t'(DEPTH);
    localparam cnt_t  AFULL    = cnt_t'(AFULL_LVL);

    ptr_t    wr_ptr_q;
    ptr_t    rd_ptr_q;
    mcnt_t   mem_cnt_q;
    logic    inflight_q;
    cnt_t    total_q;
    cnt_t    total_next;
    logic    afull_q;
    logic    push_fire;
    logic    pop_fire;
    logic    read_issue;
    ob_cnt_t ob_cnt;
    logic [2:0] ob_occ;
    logic    debug_unused;

    // The trace enable is kept for pin compatibility with the memory wrapper.
    assign debug_unused = debugen_in;

    assign push_ready_out = (mem_cnt_q != MEM_FULL);
    assign push_fire      = push_valid_in && push_ready_out;

    // Only read when the word has a guaranteed slot in the out buffer,
    // counting the slot that a same-cycle pop frees up.
    assign ob_occ     = {1'b0, ob_cnt} + {2'b00, inflight_q};
    assign read_issue = (mem_cnt_q != '0) && (ob_occ < (3'(OB_DEPTH) + {2'b00, pop_fire}));

    assign mem_write_out      = push_fire;
    assign mem_write_addr_out = wr_ptr_q;
    assign mem_write_data_out = push_data_in;
    assign mem_write_mask_out = '1;
    assign mem_read_out       = read_issue;
    assign mem_read_addr_out  = rd_ptr_q;

    assign count_out       = total_q;
    assign almost_full_out = afull_q;

    always_comb begin
        total_next = total_q + cnt_t'(push_fire) - cnt_t'(pop_fire);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            total_q    <= '0;
            afull_q    <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (read_issue) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            mem_cnt_q  <= mem_cnt_q + mcnt_t'(push_fire) - mcnt_t'(read_issue);
            inflight_q <= read_issue;
            total_q    <= total_next;
            afull_q    <= (total_next >= AFULL);
        end
    end

    mem_fifo_outbuf #(
        .WIDTH (W)
    ) u_outbuf (
        .clk           (clk),
        .reset         (reset),
        .cap_valid_in  (inflight_q),
        .cap_data_in   (mem_read_data_in),
        .pop_ready_in  (pop_ready_in),
        .pop_valid_out (pop_valid_out),
        .pop_data_out  (pop_data_out),
        .pop_fire_out  (pop_fire),
        .cnt_out       (ob_cnt)
    );

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Scoreboard bench for mem_fifo_ctrl with a behavioural 1-cycle-latency memory
// beside it; the reference model is a plain queue with capacity DEPTH+2.
module tb_mem_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH + 2;
    localparam int AFULL = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push_valid_in = 1'b0;
    logic [31:0] push_data_in = '0;
    logic        push_ready_out;
    logic        pop_valid_out;
    logic [31:0] pop_data_out;
    logic        pop_ready_in = 1'b0;
    logic [4:0]  count_out;
    logic        almost_full_out;
    logic [3:0]  mem_write_addr_out;
    logic        mem_write_out;
    logic [31:0] mem_write_data_out;
    logic [3:0]  mem_write_mask_out;
    logic [3:0]  mem_read_addr_out;
    logic        mem_read_out;
    logic [31:0] mem_read_data_in;
    logic        debugen_in = 1'b0;

    logic [31:0] mem_array [DEPTH];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          max_cnt = 0;

    always #5 clk = ~clk;

    mem_fifo_ctrl #(
        .WIDTH_BYTES (4),
        .DEPTH       (DEPTH),
        .AFULL_LVL   (AFULL)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .push_valid_in      (push_valid_in),
        .push_data_in       (push_data_in),
        .push_ready_out     (push_ready_out),
        .pop_valid_out      (pop_valid_out),
        .pop_data_out       (pop_data_out),
        .pop_ready_in       (pop_ready_in),
        .count_out          (count_out),
        .almost_full_out    (almost_full_out),
        .mem_write_addr_out (mem_write_addr_out),
        .mem_write_out      (mem_write_out),
        .mem_write_data_out (mem_write_data_out),
        .mem_write_mask_out (mem_write_mask_out),
        .mem_read_addr_out  (mem_read_addr_out),
        .mem_read_out       (mem_read_out),
        .mem_read_data_in   (mem_read_data_in),
        .debugen_in         (debugen_in)
    );

    // Behavioural memory: SHOWAHEAD=0, read data one cycle after issue.
    always @(posedge clk) begin
        if (mem_write_out && mem_write_mask_out == 4'hF) begin
            mem_array[mem_write_addr_out] <= mem_write_data_out;
        end
        if (mem_read_out) begin
            mem_read_data_in <= mem_array[mem_read_addr_out];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic pv, input logic [31:0] pd, input logic pr);
        @(posedge clk);
        #1;
        push_valid_in = pv;
        push_data_in  = pd;
        pop_ready_in  = pr;
    endtask

    // Monitor: the model is a bounded queue; occupancy, flags and pop data follow from it.
    always @(negedge clk) begin
        int   sz;
        logic acc;
        if (!reset) begin
            exp_q.delete();
            check_output("rst_count", 32'(count_out), 32'd0);
            check_output("rst_pop_valid", 32'(pop_valid_out), 32'd0);
            check_output("rst_push_ready", 32'(push_ready_out), 32'd1);
            check_output("rst_mem_read", 32'(mem_read_out), 32'd0);
        end else begin
            sz = exp_q.size();
            if (int'(count_out) > max_cnt) max_cnt = int'(count_out);
            check_output("count", 32'(count_out), 32'(sz));
            check_output("almost_full", 32'(almost_full_out), 32'(sz >= AFULL));
            check_output("push_ready", 32'(push_ready_out), 32'(sz < CAP));
            if (pop_valid_out && pop_ready_in) begin
                if (sz == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL pop_on_empty: got 0x%08h, expected no word", pop_data_out);
                end else begin
                    check_output("pop_data", pop_data_out, exp_q.pop_front());
                end
            end
            acc = push_valid_in && (sz < CAP);
            check_output("mem_write", 32'(mem_write_out), 32'(acc));
            if (acc) exp_q.push_back(push_data_in);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        found;
        logic        started;
        int          gaps;
        int          pops;
        int          sent;
        int          rcv;
        logic [31:0] pd;

        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Single word through an empty FIFO.
        apply_stimulus(1'b1, 32'hA5A5A5A5, 1'b1);
        @(negedge clk);
        check_output("lat_mem_write", 32'(mem_write_out), 32'd1);
        check_output("lat_waddr", 32'(mem_write_addr_out), 32'd0);
        check_output("lat_wdata", mem_write_data_out, 32'hA5A5A5A5);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_output("lat_mem_read", 32'(mem_read_out), 32'd1);
        check_output("lat_raddr", 32'(mem_read_addr_out), 32'd0);
        check_output("lat_count", 32'(count_out), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (pop_valid_out) begin
                found = 1'b1;
                check_output("lat_pop_data", pop_data_out, 32'hA5A5A5A5);
            end
        end
        check_output("lat_pop_valid_seen", 32'(found), 32'd1);
        repeat (3) apply_stimulus(1'b0, 32'h0, 1'b1);

        // Fill to capacity with the consumer stalled.
        for (int i = 0; i < CAP; i++) apply_stimulus(1'b1, 32'(i), 1'b0);
        apply_stimulus(1'b1, 32'h99, 1'b0);
        @(negedge clk);
        check_output("full_count", 32'(count_out), 32'(CAP));
        check_output("full_push_ready", 32'(push_ready_out), 32'd0);
        check_output("full_afull", 32'(almost_full_out), 32'd1);
        apply_stimulus(1'b1, 32'h99, 1'b0);

        // Push and pop together at full: push refused, pop taken, push accepted next.
        apply_stimulus(1'b1, 32'hBEEF, 1'b1);
        @(negedge clk);
        check_output("fullpp_push_ready", 32'(push_ready_out), 32'd0);
        check_output("fullpp_pop_valid", 32'(pop_valid_out), 32'd1);
        apply_stimulus(1'b1, 32'hBEEF, 1'b0);
        @(negedge clk);
        check_output("fullpp_next_push_ready", 32'(push_ready_out), 32'd1);
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1'b0, 32'h0, 1'b1);
            @(negedge clk);
            if (count_out == 5'd0 && !pop_valid_out) break;
        end
        check_output("drain_empty", 32'(count_out), 32'd0);

        // Continuous streaming: no bubbles once the head has arrived.
        started = 1'b0;
        gaps = 0;
        pops = 0;
        for (int c = 0; c < 110; c++) begin
            apply_stimulus(c < 100, 32'(1000 + c), 1'b1);
            @(negedge clk);
            if (pop_valid_out) begin
                started = 1'b1;
                pops++;
            end else if (started && pops < 100) begin
                gaps++;
            end
        end
        check_output("stream_gaps", 32'(gaps), 32'd0);
        check_output("stream_pops", 32'(pops), 32'd100);

        // Pointer wrap with random consumer stalls.
        sent = 0;
        rcv = 0;
        max_cnt = 0;
        pd = $urandom;
        for (int c = 0; c < 600 && rcv < 3 * DEPTH; c++) begin
            apply_stimulus(sent < 3 * DEPTH, pd, 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (push_valid_in && push_ready_out) begin
                sent++;
                pd = $urandom;
            end
            if (pop_valid_out && pop_ready_in) rcv++;
        end
        check_output("wrap_received", 32'(rcv), 32'(3 * DEPTH));
        check_output("wrap_max_le_cap", 32'(max_cnt <= CAP), 32'd1);

        // Reset with words queued and a read in flight.
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 32'(32'h100 + i), 1'b0);
        repeat (3) apply_stimulus(1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        @(posedge clk);
        #1 pop_ready_in = 1'b0;
        #1 reset = 1'b0;
        #1;
        check_output("midrst_pop_valid", 32'(pop_valid_out), 32'd0);
        check_output("midrst_count", 32'(count_out), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        apply_stimulus(1'b1, 32'h1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (pop_valid_out) begin
                found = 1'b1;
                check_output("postrst_first_pop", pop_data_out, 32'h1);
            end
        end
        check_output("postrst_pop_seen", 32'(found), 32'd1);
        repeat (4) apply_stimulus(1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
